output_display_driver: RTL and testbench
========================================

# output_display_driver

Converts the processor's 32-bit `OutputData` word into eight active-low seven-segment digit patterns for the board display. It sits directly downstream of the processor top. It runs a sequential shift-and-add-3 (double-dabble) binary-to-BCD conversion whenever the word changes, then drives the decimal value with leading-zero blanking and an overflow indication.

## Interface

Parameters:
- `DATA_W`, 32, width of the binary input
- `DIGITS`, 8, number of displayed decimal digits
- `BCD_DIGITS`, 10, internal BCD digits; must satisfy 10^BCD_DIGITS > 2^DATA_W

Ports:
- `Clock`, in, 1, single system clock, rising edge
- `Reset`, in, 1, asynchronous, active-low reset
- `OutputData`, in, DATA_W, binary value to display; unsigned
- `Segments`, out, DIGITS*7, digit k occupies [7k+6:7k]; bit order gfedcba; active-low; digit 0 is least significant
- `Busy`, out, 1, high while a conversion is in progress
- `Overflow`, out, 1, high while the displayed value exceeds 10^DIGITS − 1

## Operation

- Decided: one clock. `Reset` is asynchronous and active-low.
- The FSM has three states: IDLE, SHIFT and LATCH.
- **IDLE**
  - A conversion starts when `pending` is set or when `OutputData` differs from `last_value`.
  - On start: capture `OutputData` into both `bin_sr` and `last_value`, clear `bcd` (BCD_DIGITS×4 bits), clear `cnt`, clear `pending`, and go to SHIFT.
- **SHIFT** (one bit per cycle)
  - First, every BCD nibble ≥ 5 gets +3.
  - Then `{bcd, bin_sr}` shifts left by 1.
  - `cnt` increments. After DATA_W shifts, go to LATCH.
- **LATCH**
  - `Overflow` = any BCD nibble at index ≥ DIGITS is nonzero.
  - If `Overflow` = 1, every digit shows '-' (7'b0111111).
  - Otherwise each digit shows its nibble encoding. A digit is blanked (7'b1111111) when it and all higher digits are zero. Digit 0 is never blanked, so value 0 shows "0" (7'b1000000).
  - `Segments` and `Overflow` register in this state. Return to IDLE.
- **Changes during a conversion**
  - Changes of `OutputData` during SHIFT or LATCH are ignored.
  - On return to IDLE the comparison against `last_value` picks up the newest value, so the final value is always displayed.
- **Reset value** (reset asserted)
  - State = IDLE, `Segments` all 1 (blank), `Busy` = 0, `Overflow` = 0, `last_value` = 0, `pending` = 1.
  - Because `pending` = 1, the first conversion always runs after reset, including when the input is 0.
- **Reset mid-conversion** aborts immediately: outputs take their reset values and the partial BCD is discarded.
- Nibble values 10–15 cannot occur after a correct conversion. The encoder maps them to blank.

## Timing

- `Busy` = 1 exactly in SHIFT and LATCH: DATA_W + 1 = 33 cycles per conversion.
- Latency is 34 rising edges from the first edge sampling a new `OutputData` in IDLE to new `Segments`/`Overflow` being visible: 1 capture, 32 shift, 1 latch.
- `Segments` and `Overflow` change only on the LATCH edge and hold stable otherwise. They are glitch-free because they are registered.
- Back-to-back changes: the second conversion starts on the first IDLE cycle after LATCH, one cycle after `Busy` falls.
- There is no input handshake. `OutputData` is treated as level data from the same clock domain.

## Structure

- Shared package `display_pkg`:
  - state enum {IDLE, SHIFT, LATCH}
  - segment constants SEG_BLANK, SEG_DASH
  - 16-entry digit-to-segment table
  - default DIGITS / BCD_DIGITS
- One combinational sub-module `seg7_encoder` (4-bit nibble + blank flag → 7-bit active-low pattern), instantiated DIGITS times.
- The add-3 correction is a generate loop over BCD nibbles inside the top. It is not a separate module.

## Test plan

- Reset released with `OutputData`=0: `Segments` all 1 and `Busy`=0 during reset. `Busy` rises on the first edge after release. After 34 edges digit 0 = 7'b1000000, digits 1–7 blank, `Overflow`=0.
- `OutputData`=12345678 → after 34 cycles digits 7..0 show 1,2,3,4,5,6,7,8 and `Overflow`=0. `OutputData`=305 → digits 2..0 show 3,0,5 (the inner zero is displayed), digits 3–7 blank.
- `OutputData`=99999999 → all eight digits show 9, `Overflow`=0. Then 100000000 → all digits '-', `Overflow`=1. Then 0xFFFFFFFF → all digits '-', `Overflow`=1.
- `OutputData` goes 7 → 42 at cycle 10 of a conversion of 7 → the display shows "7" at LATCH. A second conversion starts 1 cycle later and shows "42" after 34 more cycles. `Segments` never shows any intermediate value.
- Constant `OutputData` after a conversion: `Busy` stays 0 for 100 cycles and `Segments` is unchanged.
- `Reset` asserted at shift cycle 15 of converting 12345678: outputs go blank/0 immediately, without waiting for a clock edge. After release the pending conversion redisplays 12345678 after 34 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display driver.
// Holds the converter FSM states, the segment constants (active-low, bit
// order gfedcba) and the nibble-to-segment lookup table.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DIGITS_DEF     = 8;
  localparam int BCD_DIGITS_DEF = 10;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the pattern for nibble n. Nibbles 10..15 never come out of a
  // correct conversion, so they map to blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'b0010000,   // 9
    7'b0000000,   // 8
    7'b1111000,   // 7
    7'b0000010,   // 6
    7'b0010010,   // 5
    7'b0011001,   // 4
    7'b0110000,   // 3
    7'b0100100,   // 2
    7'b1111001,   // 1
    7'b1000000    // 0
  };

endpackage

// File: rtl/seg7_encoder.sv
// Combinational digit encoder.
// Ports: nib   - BCD nibble to show
//        blank - force the digit dark (leading-zero blanking)
//        seg   - active-low gfedcba pattern
module seg7_encoder
  import display_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_TABLE[nib];

endmodule

// File: rtl/output_display_driver.sv
// Binary-to-seven-segment display driver.
// Converts OutputData to BCD with a sequential shift-and-add-3 pass
// (one bit per clock) whenever the value changes, then registers the
// encoded digits with leading-zero blanking, or all dashes on overflow.
// Ports: Clock      - system clock, rising edge
//        Reset      - asynchronous, active-low
//        OutputData - unsigned binary value to display
//        Segments   - DIGITS x 7 active-low patterns, digit 0 least significant
//        Busy       - conversion in progress (SHIFT or LATCH)
//        Overflow   - value does not fit in DIGITS decimal digits
module output_display_driver
  import display_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = DIGITS_DEF,
  parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   OutputData,
  output logic [DIGITS*7-1:0] Segments,
  output logic                Busy,
  output logic                Overflow
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t                         state, state_nxt;
  logic [DATA_W-1:0]              bin_sr, last_value;
  logic [BCD_DIGITS-1:0][3:0]     bcd, bcd_adj;
  logic [CNT_W-1:0]               cnt;
  logic                           pending;
  logic                           start;
  logic [DIGITS-1:0]              blank;
  logic                           run_zero;
  logic                           ovf_nxt;
  logic [DIGITS-1:0][6:0]         enc_seg, seg_q;
  logic                           ovf_q;

  // pending forces one conversion after reset even if the input is 0.
  assign start = (state == IDLE) && (pending || (OutputData != last_value));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before each shift.
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    assign bcd_adj[i] = (bcd[i] >= 4'd5) ? bcd[i] + 4'd3 : bcd[i];
  end

  // Digit k is dark when it and every higher displayed digit are zero;
  // digit 0 always lights so a zero value reads "0".
  always_comb begin
    run_zero = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run_zero = run_zero && (bcd[k] == 4'd0);
      blank[k] = run_zero;
    end
  end

  always_comb begin
    ovf_nxt = 1'b0;
    for (int k = DIGITS; k < BCD_DIGITS; k++)
      ovf_nxt = ovf_nxt | (bcd[k] != 4'd0);
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_enc
    seg7_encoder u_enc (
      .nib   (bcd[d]),
      .blank (blank[d]),
      .seg   (enc_seg[d])
    );
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bin_sr     <= '0;
      last_value <= '0;
      bcd        <= '0;
      cnt        <= '0;
      pending    <= 1'b1;
      seg_q      <= {DIGITS{SEG_BLANK}};
      ovf_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bin_sr     <= OutputData;
          last_value <= OutputData;
          bcd        <= '0;
          cnt        <= '0;
          pending    <= 1'b0;
        end
        SHIFT: begin
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          cnt           <= cnt + CNT_W'(1);
        end
        LATCH: begin
          seg_q <= ovf_nxt ? {DIGITS{SEG_DASH}} : enc_seg;
          ovf_q <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  assign Segments = seg_q;
  assign Overflow = ovf_q;
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_output_display_driver.sv
// Self-checking bench for output_display_driver: directed boundary values,
// randomized values, mid-conversion input change, idle hold and
// asynchronous reset during a conversion, all against a decimal model.
module tb_output_display_driver;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] OutputData = '0;
  logic [55:0] Segments;
  logic        Busy, Overflow;

  int nchk = 0;
  int nerr = 0;
  logic [55:0] cur_exp = {8{7'b1111111}};
  logic [31:0] last_drv = '0;

  output_display_driver dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .OutputData (OutputData),
    .Segments   (Segments),
    .Busy       (Busy),
    .Overflow   (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal reference: digit k = (v / 10^k) % 10, dark when v < 10^k (k > 0).
  function automatic logic [55:0] model_seg(input logic [31:0] v);
    longint unsigned x, p;
    logic [55:0] r;
    x = 64'(v);
    if (x > 64'd99999999) return {8{7'b0111111}};
    r = '0;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && x < p) r[7*k +: 7] = 7'h7F;
      else                r[7*k +: 7] = pat(int'((x / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return v > 32'd99999999;
  endfunction

  // Drives v and follows the 34-edge conversion. Caller is just after a
  // falling edge with the DUT idle (or reset just released).
  task automatic conv(input string tag, input logic [31:0] v);
    int hold_bad;
    logic [55:0] e;
    hold_bad = 0;
    OutputData = v;
    last_drv = v;
    e = model_seg(v);
    for (int i = 1; i <= 34; i++) begin
      @(posedge Clock); #1;
      if (i == 1) chk({tag, "_busy_rise"}, 64'(Busy), 64'd1);
      if (i < 34 && Segments !== cur_exp) hold_bad++;
      if (i == 34) begin
        chk({tag, "_seg"}, 64'(Segments), 64'(e));
        chk({tag, "_ovf"}, 64'(Overflow), 64'(model_ovf(v)));
        chk({tag, "_busy_fall"}, 64'(Busy), 64'd0);
      end
    end
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    cur_exp = e;
    @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int bad;

    // Reset with input 0
    repeat (3) @(negedge Clock);
    chk("rst_seg", 64'(Segments), 64'({8{7'b1111111}}));
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_ovf", 64'(Overflow), 64'd0);
    Reset = 1'b1;
    conv("zero", 32'd0);

    // Directed values
    conv("d12345678", 32'd12345678);
    conv("d305", 32'd305);
    conv("d99999999", 32'd99999999);
    conv("d100000000", 32'd100000000);
    conv("dffffffff", 32'hFFFFFFFF);
    conv("d1", 32'd1);
    conv("d10000000", 32'd10000000);

    // Randomized values
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 99999999);
        2: v = $urandom_range(0, 999);
        default: v = $urandom_range(99999990, 100000010);
      endcase
      if (v == last_drv) v = v ^ 32'd1;
      conv("rnd", v);
    end

    // Input change mid-conversion: 7 shows first, then 42 without any
    // intermediate pattern appearing.
    begin
      logic [55:0] e7, e42;
      e7 = model_seg(32'd7);
      e42 = model_seg(32'd42);
      bad = 0;
      OutputData = 32'd7;
      for (int i = 1; i <= 68; i++) begin
        @(posedge Clock); #1;
        if (i < 34 && Segments !== cur_exp) bad++;
        if (i > 34 && i < 68 && Segments !== e7) bad++;
        if (i == 10) begin
          @(negedge Clock);
          OutputData = 32'd42;
        end
        if (i == 34) begin
          chk("chg_first_seg", 64'(Segments), 64'(e7));
          chk("chg_first_busy", 64'(Busy), 64'd0);
        end
        if (i == 35) chk("chg_restart_busy", 64'(Busy), 64'd1);
        if (i == 68) begin
          chk("chg_second_seg", 64'(Segments), 64'(e42));
          chk("chg_second_busy", 64'(Busy), 64'd0);
        end
      end
      chk("chg_no_intermediate", 64'(bad), 64'd0);
      cur_exp = e42;
      last_drv = 32'd42;
      @(negedge Clock);
    end

    // Constant input: stays idle and stable
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Busy !== 1'b0 || Segments !== cur_exp) bad++;
    end
    chk("idle_hold", 64'(bad), 64'd0);

    // Asynchronous reset in the middle of a conversion
    OutputData = 32'd12345678;
    repeat (16) @(posedge Clock);
    #2;
    chk("mid_busy_before", 64'(Busy), 64'd1);
    Reset = 1'b0;
    #1;
    chk("mid_rst_seg", 64'(Segments), 64'({8{7'b1111111}}));
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_ovf", 64'(Overflow), 64'd0);
    cur_exp = {8{7'b1111111}};
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    conv("post_rst", 32'd12345678);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
